// File: rtl/rtc_bcd_counter_if.sv
// Bundle of the rtc_bcd_counter control, load, alarm and time-output signals.
// Latency: none (wiring only).
// Backpressure: none; every signal is a level or a single-cycle strobe.
//
// master: drives sec_q/run/load/load_*/alarm_* and observes hh/mm/ss/tick/load_err/alarm.
// slave : the counter itself.
interface rtc_bcd_counter_if;
  logic       sec_q;
  logic       run;
  logic       load;
  logic [7:0] load_hh;
  logic [7:0] load_mm;
  logic [7:0] load_ss;
  logic       alarm_en;
  logic [7:0] alarm_hh;
  logic [7:0] alarm_mm;
  logic [7:0] hh;
  logic [7:0] mm;
  logic [7:0] ss;
  logic       tick;
  logic       load_err;
  logic       alarm;

  modport master (
    output sec_q, run, load, load_hh, load_mm, load_ss, alarm_en, alarm_hh, alarm_mm,
    input  hh, mm, ss, tick, load_err, alarm
  );

  modport slave (
    input  sec_q, run, load, load_hh, load_mm, load_ss, alarm_en, alarm_hh, alarm_mm,
    output hh, mm, ss, tick, load_err, alarm
  );
endinterface

// File: rtl/rtc_bcd_counter.sv
// BCD hh:mm:ss time-of-day counter advanced by rising edges of a 1 Hz square wave.
// Latency: 2 clk edges from sec_q sampled high to new time + tick (+2 with TICK_SYNC=1); load is 1 edge.
// Backpressure: none; edges seen while paused or during a load are dropped, never queued.
//
// Ports: clk, reset (async, active-low), bus (rtc_bcd_counter_if.slave):
//   in  sec_q, run, load, load_hh/mm/ss, alarm_en, alarm_hh/mm
//   out hh, mm, ss (BCD), tick, load_err, alarm (one-cycle pulses)
// Parameter TICK_SYNC=1 puts a 2-flop synchronizer in front of the edge detector.
// Define RTC_BCD_ALARM_EN to build the alarm comparator; otherwise alarm is tied 0.
module rtc_bcd_counter #(
  parameter bit TICK_SYNC = 1'b0
) (
  input logic               clk,
  input logic               reset,
  rtc_bcd_counter_if.slave  bus
);

  // Increment a valid BCD byte; callers handle the wrap values themselves.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Nibbles must be decimal digits; with that guaranteed, raw byte compare equals BCD compare.
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  // ---------------------------------------------------------------- input path
  logic sec_in;

  generate
    if (TICK_SYNC) begin : g_sync
      logic sync0_q, sync1_q;
      // Reset high like s1/s2 so a wave already high at reset release is not an edge.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync0_q <= 1'b1;
          sync1_q <= 1'b1;
        end else begin
          sync0_q <= bus.sec_q;
          sync1_q <= sync0_q;
        end
      end
      assign sec_in = sync1_q;
    end else begin : g_nosync
      assign sec_in = bus.sec_q;
    end
  endgenerate

  // ---------------------------------------------------------------- state
  logic       s1_q, s1_d, s2_q, s2_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic       tick_q, tick_d, load_err_q, load_err_d, alarm_q, alarm_d;

  logic       rise;
  logic       ss_wrap, mm_wrap, hh_wrap;
  logic [7:0] hh_nx, mm_nx, ss_nx;
  logic       load_ok;
  logic       alarm_hit;

  // Next time after one second, computed as a whole so carries land in one update.
  always_comb begin
    ss_wrap = (ss_q == 8'h59);
    mm_wrap = (mm_q == 8'h59);
    hh_wrap = (hh_q == 8'h23);
    ss_nx   = ss_wrap ? 8'h00 : bcd_inc(ss_q);
    mm_nx   = mm_q;
    hh_nx   = hh_q;
    if (ss_wrap) begin
      mm_nx = mm_wrap ? 8'h00 : bcd_inc(mm_q);
      if (mm_wrap) hh_nx = hh_wrap ? 8'h00 : bcd_inc(hh_q);
    end
  end

  assign load_ok = bcd_ok(bus.load_hh, 8'h23) && bcd_ok(bus.load_mm, 8'h59) &&
                   bcd_ok(bus.load_ss, 8'h59);

`ifdef RTC_BCD_ALARM_EN
  // Compared against the post-advance time so the pulse coincides with tick.
  assign alarm_hit = bus.alarm_en && (hh_nx == bus.alarm_hh) &&
                     (mm_nx == bus.alarm_mm) && (ss_nx == 8'h00);
`else
  logic unused_alarm_inputs;
  assign unused_alarm_inputs = ^{bus.alarm_en, bus.alarm_hh, bus.alarm_mm};
  assign alarm_hit = 1'b0;
`endif

  always_comb begin
    s1_d       = sec_in;
    s2_d       = s1_q;
    rise       = s1_q & ~s2_q;
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    tick_d     = 1'b0;
    load_err_d = 1'b0;
    alarm_d    = 1'b0;
    // Load wins over a coincident edge; the edge is consumed by s2 and lost.
    if (bus.load) begin
      if (load_ok) begin
        hh_d = bus.load_hh;
        mm_d = bus.load_mm;
        ss_d = bus.load_ss;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (rise && bus.run) begin
      hh_d    = hh_nx;
      mm_d    = mm_nx;
      ss_d    = ss_nx;
      tick_d  = 1'b1;
      alarm_d = alarm_hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q       <= 1'b1;
      s2_q       <= 1'b1;
      hh_q       <= 8'h00;
      mm_q       <= 8'h00;
      ss_q       <= 8'h00;
      tick_q     <= 1'b0;
      load_err_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      tick_q     <= tick_d;
      load_err_q <= load_err_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus.hh       = hh_q;
  assign bus.mm       = mm_q;
  assign bus.ss       = ss_q;
  assign bus.tick     = tick_q;
  assign bus.load_err = load_err_q;
  assign bus.alarm    = alarm_q;

endmodule
